// File: rtl/i2c_target_responder_pkg.sv
// Shared I2C constants, the target FSM state type and a saturating byte counter helper.
package i2c_typedefs;

  localparam int I2C_ADDR_WIDTH = 7;
  localparam int I2C_BYTE_WIDTH = 8;
  localparam logic [I2C_ADDR_WIDTH-1:0] I2C_DEFAULT_TARGET_ADDR = 7'h22;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_IGNORE
  } i2c_target_state_t;

  function automatic logic [I2C_BYTE_WIDTH-1:0] sat_inc8(input logic [I2C_BYTE_WIDTH-1:0] v);
    return (v == '1) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_target_responder_line_sync.sv
// Two-flop synchronizer for SCL/SDA plus a history flop; flags SCL edges and START/STOP.
// Detection outputs are combinational from the synchronized and history flops.
module i2c_line_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_hist;
  logic       r_sda_hist;

  // Reset to the idle-bus level so release of reset does not look like an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_hist <= 1'b1;
      r_sda_hist <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], i_sda};
      r_scl_hist <= r_scl_sync[1];
      r_sda_hist <= r_sda_sync[1];
    end
  end

  assign o_sda      = r_sda_sync[1];
  assign o_scl_rise = r_scl_sync[1] & ~r_scl_hist;
  assign o_scl_fall = ~r_scl_sync[1] & r_scl_hist;
  assign o_start    = r_scl_sync[1] & r_scl_hist & r_sda_hist & ~r_sda_sync[1];
  assign o_stop     = r_scl_sync[1] & r_scl_hist & ~r_sda_hist & r_sda_sync[1];

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target with a byte buffer: address match, ACK, write capture and read return.
// Optional SCL clock stretching after every 9th-clock fall when I2C_TARGET_CLK_STRETCH_EN is defined.
module i2c_target_responder
  import i2c_typedefs::*;
#(
  parameter logic [I2C_ADDR_WIDTH-1:0] TARGET_ADDR    = I2C_DEFAULT_TARGET_ADDR,
  parameter int                        MEM_DEPTH      = 32,
  parameter int                        STRETCH_CYCLES = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         scl_i,
  input  logic                         sda_i,
  output logic                         sda_drv_o,
  output logic                         scl_drv_o,
  input  logic                         ld_en_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] ld_addr_i,
  input  logic [I2C_BYTE_WIDTH-1:0]    ld_data_i,
  output logic [I2C_BYTE_WIDTH-1:0]    obs_data_o,
  output logic                         busy_o,
  output logic                         rw_o,
  output logic [7:0]                   byte_cnt_o,
  output logic                         done_o
);

  localparam int AW = $clog2(MEM_DEPTH);

  if (MEM_DEPTH < 4 || MEM_DEPTH > 256 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0 ||
      STRETCH_CYCLES < 1) begin : g_bad_param
    $error("i2c_target_responder: MEM_DEPTH must be a power of 2 in 4..256, STRETCH_CYCLES >= 1");
  end

  logic w_sda;
  logic w_rise;
  logic w_fall_raw;
  logic w_fall;
  logic w_start;
  logic w_stop;

  i2c_line_sync u_sync (
    .i_clk      (clk_i),
    .i_rst_n    (rst_i),
    .i_scl      (scl_i),
    .i_sda      (sda_i),
    .o_sda      (w_sda),
    .o_scl_rise (w_rise),
    .o_scl_fall (w_fall_raw),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  i2c_target_state_t           r_state;
  i2c_target_state_t           w_state_nxt;
  logic [3:0]                  r_bit_cnt;
  logic [3:0]                  w_bit_cnt_nxt;
  logic [I2C_BYTE_WIDTH-1:0]   r_shift;
  logic [I2C_BYTE_WIDTH-1:0]   w_shift_nxt;
  logic [AW-1:0]               r_ptr;
  logic [AW-1:0]               w_ptr_nxt;
  logic [7:0]                  r_byte_cnt;
  logic [7:0]                  w_byte_cnt_nxt;
  logic                        r_rw;
  logic                        w_rw_nxt;
  logic                        r_busy;
  logic                        w_busy_nxt;
  logic                        r_done;
  logic                        w_done_nxt;
  logic                        r_sda_drv;
  logic                        w_sda_drv_nxt;
  logic                        r_nak;
  logic                        w_nak_nxt;
  logic                        w_mem_we;
  logic [I2C_BYTE_WIDTH-1:0]   w_rd_byte;
  logic [I2C_BYTE_WIDTH-1:0]   r_mem [MEM_DEPTH];

`ifdef I2C_TARGET_CLK_STRETCH_EN
  localparam int SCW = $clog2(STRETCH_CYCLES + 1);
  logic [SCW-1:0] r_stretch_cnt;
  logic           w_stretch_go;

  // Falls seen while we hold SCL are our own and must not advance the FSM.
  assign w_fall       = w_fall_raw && (r_stretch_cnt == '0);
  assign w_stretch_go = w_fall && !w_start && !w_stop &&
                        (r_state inside {S_ADDR_ACK, S_WR_ACK, S_RD_ACK});
  assign scl_drv_o    = (r_stretch_cnt != '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stretch_cnt <= '0;
    end else if (w_stretch_go) begin
      r_stretch_cnt <= SCW'(STRETCH_CYCLES);
    end else if (r_stretch_cnt != '0) begin
      r_stretch_cnt <= r_stretch_cnt - SCW'(1);
    end
  end
`else
  assign w_fall    = w_fall_raw;
  assign scl_drv_o = 1'b0;
`endif

  assign w_rd_byte = r_mem[r_ptr];

  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_ptr_nxt      = r_ptr;
    w_byte_cnt_nxt = r_byte_cnt;
    w_rw_nxt       = r_rw;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_sda_drv_nxt  = r_sda_drv;
    w_nak_nxt      = r_nak;
    w_mem_we       = 1'b0;

    if (w_stop) begin
      w_state_nxt   = S_IDLE;
      w_sda_drv_nxt = 1'b0;
      w_busy_nxt    = 1'b0;
      w_done_nxt    = r_busy;
    end else if (w_start) begin
      w_state_nxt   = S_ADDR;
      w_bit_cnt_nxt = 4'd0;
      w_sda_drv_nxt = 1'b0;
      w_busy_nxt    = 1'b0;
      w_done_nxt    = r_busy;
    end else begin
      unique case (r_state)
        S_ADDR, S_WR_DATA: begin
          if (w_rise) begin
            w_shift_nxt   = {r_shift[6:0], w_sda};
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end else if (w_fall && r_bit_cnt == 4'd8) begin
            if (r_state == S_ADDR) begin
              if (r_shift[7:1] == TARGET_ADDR) begin
                w_state_nxt    = S_ADDR_ACK;
                w_ptr_nxt      = '0;
                w_byte_cnt_nxt = 8'd0;
                w_rw_nxt       = r_shift[0];
                w_busy_nxt     = 1'b1;
                w_sda_drv_nxt  = 1'b1;
              end else begin
                w_state_nxt = S_IGNORE;
              end
            end else begin
              w_mem_we       = 1'b1;
              w_ptr_nxt      = r_ptr + AW'(1);
              w_byte_cnt_nxt = sat_inc8(r_byte_cnt);
              w_state_nxt    = S_WR_ACK;
              w_sda_drv_nxt  = 1'b1;
            end
          end
        end
        S_ADDR_ACK, S_WR_ACK: begin
          if (w_fall) begin
            w_bit_cnt_nxt = 4'd0;
            if (r_state == S_ADDR_ACK && r_rw) begin
              w_state_nxt   = S_RD_DATA;
              w_shift_nxt   = w_rd_byte;
              w_sda_drv_nxt = ~w_rd_byte[7];
            end else begin
              w_state_nxt   = S_WR_DATA;
              w_sda_drv_nxt = 1'b0;
            end
          end
        end
        S_RD_DATA: begin
          if (w_rise) begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end else if (w_fall) begin
            if (r_bit_cnt == 4'd8) begin
              w_state_nxt   = S_RD_ACK;
              w_sda_drv_nxt = 1'b0;
            end else begin
              w_shift_nxt   = {r_shift[6:0], 1'b0};
              w_sda_drv_nxt = ~r_shift[6];
            end
          end
        end
        S_RD_ACK: begin
          // The master's ACK/NAK is captured on the rise; the next byte starts on the fall.
          if (w_rise) begin
            w_nak_nxt      = w_sda;
            w_byte_cnt_nxt = sat_inc8(r_byte_cnt);
            if (!w_sda) begin
              w_ptr_nxt = r_ptr + AW'(1);
            end
          end else if (w_fall) begin
            if (r_nak) begin
              w_state_nxt = S_IGNORE;
            end else begin
              w_state_nxt   = S_RD_DATA;
              w_bit_cnt_nxt = 4'd0;
              w_shift_nxt   = w_rd_byte;
              w_sda_drv_nxt = ~w_rd_byte[7];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_bit_cnt  <= 4'd0;
      r_shift    <= '0;
      r_ptr      <= '0;
      r_byte_cnt <= 8'd0;
      r_rw       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sda_drv  <= 1'b0;
      r_nak      <= 1'b0;
    end else begin
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_ptr      <= w_ptr_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_rw       <= w_rw_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_sda_drv  <= w_sda_drv_nxt;
      r_nak      <= w_nak_nxt;
    end
  end

  // Buffer is not reset; a bus write to the same entry overrides a host load.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      r_mem[r_ptr] <= r_shift;
    end
    if (ld_en_i && !(w_mem_we && ld_addr_i == r_ptr)) begin
      r_mem[ld_addr_i] <= ld_data_i;
    end
  end

  assign sda_drv_o  = r_sda_drv;
  assign obs_data_o = r_mem[ld_addr_i];
  assign busy_o     = r_busy;
  assign rw_o       = r_rw;
  assign byte_cnt_o = r_byte_cnt;
  assign done_o     = r_done;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: open-drain bus master, transaction-level buffer model, scoreboard queues.
module tb_i2c_target_responder;

  localparam int MEM_DEPTH = 32;
  localparam int Q = 6;
  localparam logic [6:0] TADDR = 7'h22;

  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       m_scl;
  logic       m_sda;
  logic       scl_bus;
  logic       sda_bus;
  logic       sda_drv;
  logic       scl_drv;
  logic       ld_en;
  logic [4:0] ld_addr;
  logic [7:0] ld_data;
  logic [7:0] obs;
  logic       busy;
  logic       rw;
  logic [7:0] byte_cnt;
  logic       done;

  assign scl_bus = m_scl & ~scl_drv;
  assign sda_bus = m_sda & ~sda_drv;

  i2c_target_responder #(
    .TARGET_ADDR    (TADDR),
    .MEM_DEPTH      (MEM_DEPTH),
    .STRETCH_CYCLES (16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .scl_i      (scl_bus),
    .sda_i      (sda_bus),
    .sda_drv_o  (sda_drv),
    .scl_drv_o  (scl_drv),
    .ld_en_i    (ld_en),
    .ld_addr_i  (ld_addr),
    .ld_data_i  (ld_data),
    .obs_data_o (obs),
    .busy_o     (busy),
    .rw_o       (rw),
    .byte_cnt_o (byte_cnt),
    .done_o     (done)
  );

  int    total = 0;
  int    bad = 0;
  string exp_name_q[$];
  int    exp_val_q[$];
  int    got_val_q[$];
  int    exp_done_q[$];
  logic [7:0] model_mem [MEM_DEPTH];
  int    pend_done = -1;
  bit    in_txn = 0;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_exp(input string name, input int v);
    exp_name_q.push_back(name);
    exp_val_q.push_back(v);
  endtask

  task automatic push_got(input int v);
    got_val_q.push_back(v);
  endtask

  // Scoreboard monitor: pairs observations with expectations in issue order.
  initial begin
    forever begin
      @(negedge clk);
      while (got_val_q.size() > 0 && exp_val_q.size() > 0) begin
        chk(exp_name_q.pop_front(), got_val_q.pop_front(), exp_val_q.pop_front());
      end
    end
  end

  // Completion monitor: every done_o pulse must match a pending transaction summary.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        int e;
        if (exp_done_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_done_q.pop_front();
          chk("done_rw", int'(rw), e / 256);
          chk("done_byte_cnt", int'(byte_cnt), e % 256);
        end
      end
    end
  end

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic scl_high();
    int n = 0;
    m_scl = 1'b1;
    while (scl_bus !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (scl_bus !== 1'b1) chk("scl_release_timeout", 0, 1);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;
    qwait();
    scl_high();
    qwait();
    qwait();
    m_scl = 1'b0;
    qwait();
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1;
    qwait();
    scl_high();
    qwait();
    b = sda_bus;
    qwait();
    m_scl = 1'b0;
    qwait();
  endtask

  task automatic send_byte(input logic [7:0] d, input string nm, input int exp_ack);
    logic a;
    push_exp(nm, exp_ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(a);
    push_got(int'(a));
  endtask

  task automatic recv_byte(input int exp, input logic ack_bit, input string nm);
    logic [7:0] d;
    logic       b;
    push_exp(nm, exp);
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    push_got(int'(d));
    send_bit(ack_bit);
  endtask

  task automatic end_txn();
    if (pend_done >= 0) exp_done_q.push_back(pend_done);
    pend_done = -1;
  endtask

  task automatic bus_start();
    if (in_txn) begin
      end_txn();
      m_sda = 1'b1;
      qwait();
      scl_high();
      qwait();
    end
    m_sda = 1'b0;
    qwait();
    m_scl = 1'b0;
    qwait();
    in_txn = 1;
  endtask

  task automatic bus_stop();
    end_txn();
    m_sda = 1'b0;
    qwait();
    scl_high();
    qwait();
    m_sda = 1'b1;
    qwait();
    qwait();
    in_txn = 0;
  endtask

  task automatic wr_txn(input logic [6:0] a, input bq_t data);
    bit m;
    m = (a == TADDR);
    bus_start();
    send_byte({a, 1'b0}, "addr_ack_w", m ? 0 : 1);
    push_exp("busy_after_addr_w", m ? 1 : 0);
    push_got(int'(busy));
    for (int i = 0; i < data.size(); i++) begin
      send_byte(data[i], "wr_data_ack", m ? 0 : 1);
      if (m) model_mem[i % MEM_DEPTH] = data[i];
    end
    if (m) pend_done = (data.size() > 255) ? 255 : data.size();
  endtask

  task automatic rd_txn(input int n);
    bus_start();
    send_byte({TADDR, 1'b1}, "addr_ack_r", 0);
    push_exp("busy_after_addr_r", 1);
    push_got(int'(busy));
    for (int i = 0; i < n; i++) begin
      recv_byte(int'(model_mem[i % MEM_DEPTH]), (i == n - 1), "rd_data");
    end
    push_exp("sda_released_after_nak", 0);
    push_got(int'(sda_drv));
    pend_done = 256 + n;
  endtask

  task automatic host_load(input int a, input logic [7:0] d);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = 5'(a);
    ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic observe(input int a);
    @(negedge clk);
    ld_addr = 5'(a);
    #1;
    push_exp("mem_observe", int'(model_mem[a]));
    push_got(int'(obs));
  endtask

  task automatic drain();
    int n = 0;
    while ((got_val_q.size() > 0 || exp_val_q.size() > 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (got_val_q.size() != exp_val_q.size()) chk("scoreboard_drain", got_val_q.size(), exp_val_q.size());
  endtask

  initial begin
    bq_t d;
    int  kind;
    int  n;
    logic [6:0] a;

    rst_n = 1'b0;
    m_scl = 1'b1;
    m_sda = 1'b1;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    repeat (4) @(negedge clk);
    push_exp("rst_sda_drv", 0);  push_got(int'(sda_drv));
    push_exp("rst_scl_drv", 0);  push_got(int'(scl_drv));
    push_exp("rst_busy", 0);     push_got(int'(busy));
    push_exp("rst_rw", 0);       push_got(int'(rw));
    push_exp("rst_byte_cnt", 0); push_got(int'(byte_cnt));
    push_exp("rst_done", 0);     push_got(int'(done));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < MEM_DEPTH; i++) host_load(i, 8'($urandom_range(0, 255)));

    d = {};
    d.push_back(8'hA5); d.push_back(8'h3C); d.push_back(8'hFF);
    wr_txn(TADDR, d);
    bus_stop();
    for (int i = 0; i < 3; i++) observe(i);

    host_load(0, 8'h5A);
    host_load(1, 8'hC3);
    rd_txn(2);
    bus_stop();

    d = {};
    d.push_back(8'h11); d.push_back(8'h22);
    wr_txn(7'h23, d);
    bus_stop();
    push_exp("busy_after_mismatch", 0);
    push_got(int'(busy));

    d = {};
    for (int i = 0; i < 34; i++) d.push_back(8'(i));
    wr_txn(TADDR, d);
    bus_stop();

    d = {};
    d.push_back(8'h77);
    wr_txn(TADDR, d);
    rd_txn(1);
    bus_stop();

    host_load(0, 8'h00);
    bus_start();
    send_byte({TADDR, 1'b1}, "addr_ack_pre_reset", 0);
    push_exp("drive_zero_bit", 1);
    push_got(int'(sda_drv));
    rst_n = 1'b0;
    #1;
    push_exp("sda_released_in_reset", 0);
    push_got(int'(sda_drv));
    push_exp("busy_in_reset", 0);
    push_got(int'(busy));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pend_done = -1;
    bus_stop();

    for (int t = 0; t < 14; t++) begin
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        d = {};
        n = $urandom_range(1, 8);
        for (int i = 0; i < n; i++) d.push_back(8'($urandom_range(0, 255)));
        wr_txn(TADDR, d);
      end else if (kind == 1) begin
        rd_txn($urandom_range(1, 4));
      end else if (kind == 2) begin
        a = 7'($urandom_range(0, 127));
        if (a == TADDR) a = TADDR + 7'd1;
        d = {};
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) d.push_back(8'($urandom_range(0, 255)));
        wr_txn(a, d);
      end else begin
        for (int i = 0; i < 3; i++) host_load($urandom_range(0, MEM_DEPTH - 1), 8'($urandom_range(0, 255)));
      end
      if (in_txn && $urandom_range(0, 1) == 1) bus_stop();
    end
    if (in_txn) bus_stop();

    for (int i = 0; i < MEM_DEPTH; i++) observe(i);
    repeat (20) @(negedge clk);
    drain();
    chk("done_pulses_missing", exp_done_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
